// File: rtl/fetch_pkg.sv
// Shared types and sizing for the in-order instruction fetch queue.
// Also provides the `TRUE / `FALSE shorthands used across the fetch RTL.
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif

package fetch_pkg;

    localparam int unsigned DEF_QUEUE_DEPTH  = 4;
    localparam int unsigned DEF_MAX_INFLIGHT = 2;
    localparam int unsigned XLEN             = 32;
    localparam int unsigned EXCP_W           = 4;

    // Bit positions inside excp_num
    localparam int unsigned EXCP_ADEF = 0;
    localparam int unsigned EXCP_TLBR = 1;
    localparam int unsigned EXCP_PIF  = 2;
    localparam int unsigned EXCP_PPI  = 3;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   inst;
        logic              excp;
        logic [EXCP_W-1:0] excp_num;
        logic              done;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_meta_fifo.sv
// Fetch queue storage: allocation at tail, in-order pop at head, icache words
// written into the oldest entry that is still waiting for one.
module fetch_meta_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_QUEUE_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            alloc,
    input  fetch_entry_t    alloc_entry,
    input  logic            pop,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_data,
    output logic            full,
    output logic            head_valid_c,
    output fetch_entry_t    head_entry_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] resp_ptr;
    logic [PTR_W-1:0] scan_idx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             empty;
    logic             resp_found;

    // Oldest queued entry still waiting for its icache word
    always_comb begin
        resp_ptr   = head;
        resp_found = `FALSE;
        scan_idx   = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if (!resp_found && (CNT_W'(i) < count) && !mem[scan_idx].done) begin
                resp_ptr   = scan_idx;
                resp_found = `TRUE;
            end
        end
    end

    assign count_nxt    = count + CNT_W'(alloc) - CNT_W'(pop);
    assign head_valid_c = !empty && mem[head].done;
    assign head_entry_c = mem[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= `FALSE;
            empty <= `TRUE;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= `FALSE;
            empty <= `TRUE;
        end else begin
            if (alloc) begin
                mem[tail] <= alloc_entry;
                tail      <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (fill && resp_found) begin
                mem[resp_ptr].inst <= fill_data;
                mem[resp_ptr].done <= `TRUE;
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// In-order instruction fetch queue between translation and decode; issues icache
// reads, discards responses cancelled by flush. FETCH_PERF_CNT_EN adds perf counters.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH  = DEF_QUEUE_DEPTH,
    parameter int unsigned MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        trans_valid,
    output logic        trans_ready,
    input  logic [31:0] trans_paddr,
    input  logic [31:0] trans_vaddr,
    input  logic        trans_uncached,
    input  logic        trans_excp,
    input  logic [3:0]  trans_excp_num,
    output logic        icache_req_valid,
    input  logic        icache_req_ready,
    output logic [31:0] icache_req_paddr,
    output logic        icache_req_uc,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_excp,
    output logic [3:0]  out_excp_num
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);

    localparam int unsigned IF_W = $clog2(MAX_INFLIGHT + 1);

    logic [IF_W-1:0] inflight;
    logic [IF_W-1:0] cancel_cnt;
    logic            q_full;
    logic            room;
    logic            accept;
    logic            issue;
    logic            resp_drop;
    logic            resp_live;
    logic            pop;
    fetch_entry_t    alloc_entry;
    fetch_entry_t    head_entry_c;

    assign room = (inflight < IF_W'(MAX_INFLIGHT));

    // Faulted fetches bypass the icache, so they only need queue space
    assign trans_ready      = !reset && !flush && !q_full &&
                              (trans_excp || (room && icache_req_ready));
    assign icache_req_valid = !reset && trans_valid && !flush && !q_full && !trans_excp && room;
    assign icache_req_paddr = trans_paddr;
    assign icache_req_uc    = trans_uncached;

    assign accept    = trans_valid && trans_ready;
    assign issue     = icache_req_valid && icache_req_ready;
    assign resp_drop = icache_resp_valid && (flush || (cancel_cnt != '0));
    assign resp_live = icache_resp_valid && !resp_drop;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        alloc_entry          = '0;
        alloc_entry.pc       = trans_vaddr;
        alloc_entry.excp     = trans_excp;
        alloc_entry.excp_num = trans_excp_num;
        alloc_entry.done     = trans_excp;
    end

    // inflight includes cancelled requests; cancel_cnt marks how many of them to drop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight   <= '0;
            cancel_cnt <= '0;
        end else begin
            inflight <= inflight + IF_W'(issue) - IF_W'(icache_resp_valid);
            if (flush) begin
                cancel_cnt <= inflight - IF_W'(icache_resp_valid);
            end else if (resp_drop) begin
                cancel_cnt <= cancel_cnt - IF_W'(1);
            end
        end
    end

    fetch_meta_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_meta_fifo (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .alloc        (accept),
        .alloc_entry  (alloc_entry),
        .pop          (pop),
        .fill         (resp_live),
        .fill_data    (icache_resp_data),
        .full         (q_full),
        .head_valid_c (out_valid),
        .head_entry_c (head_entry_c)
    );

    assign out_pc       = head_entry_c.pc;
    assign out_inst     = head_entry_c.inst;
    assign out_excp     = head_entry_c.excp;
    assign out_excp_num = head_entry_c.excp_num;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(out_valid && out_ready);
            perf_drop_cnt  <= perf_drop_cnt + 32'(resp_drop);
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random traffic against a
// queue-based reference model and an in-order icache model.
module tb_inst_fetch_queue;

    localparam int QD = 4;
    localparam int MI = 2;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        trans_valid;
    logic        trans_ready;
    logic [31:0] trans_paddr;
    logic [31:0] trans_vaddr;
    logic        trans_uncached;
    logic        trans_excp;
    logic [3:0]  trans_excp_num;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [31:0] icache_req_paddr;
    logic        icache_req_uc;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_excp;
    logic [3:0]  out_excp_num;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
    logic [31:0] m_fetch_cnt;
    logic [31:0] m_drop_cnt;
`endif

    inst_fetch_queue dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .trans_valid       (trans_valid),
        .trans_ready       (trans_ready),
        .trans_paddr       (trans_paddr),
        .trans_vaddr       (trans_vaddr),
        .trans_uncached    (trans_uncached),
        .trans_excp        (trans_excp),
        .trans_excp_num    (trans_excp_num),
        .icache_req_valid  (icache_req_valid),
        .icache_req_ready  (icache_req_ready),
        .icache_req_paddr  (icache_req_paddr),
        .icache_req_uc     (icache_req_uc),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_data  (icache_resp_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_inst          (out_inst),
        .out_excp          (out_excp),
        .out_excp_num      (out_excp_num)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_drop_cnt     (perf_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
        logic [3:0]  num;
        logic        done;
    } m_ent_t;

    typedef struct {
        logic [31:0] pa;
        int          due;
    } ic_req_t;

    m_ent_t  mq[$];
    ic_req_t icq[$];
    int      m_inflight = 0;
    int      m_cancel   = 0;
    int      cyc        = 0;
    int      ic_delay   = 2;
    int      n_cmp      = 0;
    int      n_err      = 0;

    function automatic logic [31:0] ic_data(input logic [31:0] pa);
        return pa ^ 32'h1e80_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    task automatic step(input logic f, input logic tv, input logic [31:0] pa, input logic [31:0] va,
                        input logic ex, input logic [3:0] en, input logic rr, input logic ordy);
        logic        rv, full, room, e_req, e_tr, e_ov, acc, iss, drop;
        logic [31:0] rd;
        int          k;
        m_ent_t      e;
        rv = 1'b0;
        rd = 32'h0;
        if (icq.size() > 0 && icq[0].due <= cyc) begin
            rv = 1'b1;
            rd = ic_data(icq[0].pa);
            icq.delete(0);
        end
        flush = f; trans_valid = tv; trans_paddr = pa; trans_vaddr = va;
        trans_uncached = pa[3]; trans_excp = ex; trans_excp_num = en;
        icache_req_ready = rr; icache_resp_valid = rv; icache_resp_data = rd; out_ready = ordy;
        #1;
        full  = (mq.size() == QD);
        room  = (m_inflight < MI);
        e_req = tv && !f && !full && !ex && room;
        e_tr  = !f && !full && (ex || (room && rr));
        e_ov  = (mq.size() > 0) && mq[0].done;
        check_eq("out_valid", 32'(out_valid), 32'(e_ov));
        if (e_ov) begin
            check_eq("out_pc", out_pc, mq[0].pc);
            check_eq("out_inst", out_inst, mq[0].inst);
            check_eq("out_excp", 32'(out_excp), 32'(mq[0].excp));
            check_eq("out_excp_num", 32'(out_excp_num), 32'(mq[0].num));
        end
        check_eq("trans_ready", 32'(trans_ready), 32'(e_tr));
        check_eq("icache_req_valid", 32'(icache_req_valid), 32'(e_req));
        if (e_req) begin
            check_eq("icache_req_paddr", icache_req_paddr, pa);
            check_eq("icache_req_uc", 32'(icache_req_uc), 32'(pa[3]));
        end
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
        check_eq("perf_drop_cnt", perf_drop_cnt, m_drop_cnt);
        m_fetch_cnt = m_fetch_cnt + 32'(e_ov && ordy);
`endif
        acc  = tv && e_tr;
        iss  = e_req && rr;
        drop = rv && (f || m_cancel > 0);
`ifdef FETCH_PERF_CNT_EN
        m_drop_cnt = m_drop_cnt + 32'(drop);
`endif
        if (rv && !drop) begin
            k = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (k < 0 && !mq[i].done) k = i;
            end
            check_eq("fill_target", 32'(k >= 0), 32'd1);
            if (k >= 0) begin
                e = mq[k];
                e.inst = rd;
                e.done = 1'b1;
                mq[k] = e;
            end
        end
        if (e_ov && ordy && !f) mq.delete(0);
        if (acc) begin
            e.pc = va; e.inst = 32'h0; e.excp = ex; e.num = en; e.done = ex;
            mq.push_back(e);
        end
        if (f) begin
            mq.delete();
            m_cancel = m_inflight - int'(rv);
        end else if (drop) begin
            m_cancel--;
        end
        m_inflight = m_inflight + int'(iss) - int'(rv);
        if (iss) icq.push_back('{pa, cyc + ic_delay});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, ordy);
    endtask

    // Reset is applied away from any clock edge to observe it acting asynchronously.
    task automatic apply_reset();
        reset = 1'b1;
        flush = 1'b0; trans_valid = 1'b1; trans_excp = 1'b1; trans_excp_num = 4'h1;
        trans_paddr = 32'h0; trans_vaddr = 32'h0; trans_uncached = 1'b0;
        icache_req_ready = 1'b1; icache_resp_valid = 1'b0; icache_resp_data = 32'h0; out_ready = 1'b1;
        mq.delete(); icq.delete(); m_inflight = 0; m_cancel = 0;
`ifdef FETCH_PERF_CNT_EN
        m_fetch_cnt = 32'h0; m_drop_cnt = 32'h0;
`endif
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_pc", out_pc, 32'h0);
        check_eq("rst_out_inst", out_inst, 32'h0);
        check_eq("rst_out_excp", 32'({out_excp, out_excp_num}), 32'd0);
        check_eq("rst_trans_ready", 32'(trans_ready), 32'd0);
        trans_excp = 1'b0;
        #1;
        check_eq("rst_icache_req_valid", 32'(icache_req_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; trans_valid = 1'b0;
    endtask

    initial begin
        apply_reset();

        // Single fetch, response two cycles after issue
        ic_delay = 2;
        step(1'b0, 1'b1, 32'h1c00_0000, 32'h1c00_0000, 1'b0, 4'h0, 1'b1, 1'b1);
        idle(1'b0, 2);
        check_eq("t1_valid", 32'(out_valid), 32'd1);
        check_eq("t1_pc", out_pc, 32'h1c00_0000);
        check_eq("t1_inst", out_inst, 32'h0280_0000);
        idle(1'b1, 2);

        // Faulted fetch completes first but waits behind the icache fetch
        ic_delay = 3;
        step(1'b0, 1'b1, 32'h1c00_0100, 32'h1c00_0100, 1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h1c00_0104, 32'h1c00_0104, 1'b1, 4'b0010, 1'b1, 1'b0);
        check_eq("t2_b_waits", 32'(out_valid), 32'd0);
        idle(1'b1, 6);

        // Flush with two requests in flight
        ic_delay = 4;
        step(1'b0, 1'b1, 32'h1c00_0200, 32'h9c00_0200, 1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h1c00_0204, 32'h9c00_0204, 1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'h1c00_0208, 32'h9c00_0208, 1'b0, 4'h0, 1'b1, 1'b0);
        check_eq("t3_empty", 32'(out_valid), 32'd0);
        idle(1'b0, 4);
        ic_delay = 1;
        step(1'b0, 1'b1, 32'h1c00_0300, 32'h9c00_0300, 1'b0, 4'h0, 1'b1, 1'b0);
        idle(1'b0, 1);
        check_eq("t3_new_inst", out_inst, ic_data(32'h1c00_0300));
        idle(1'b1, 3);

        // Full queue: pop at full does not admit a same-cycle accept
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 32'h1c00_0400 + 32'(4 * i), 32'h1c00_0400 + 32'(4 * i), 1'b1, 4'h4, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h1c00_0410, 32'h1c00_0410, 1'b1, 4'h8, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h1c00_0410, 32'h1c00_0410, 1'b1, 4'h8, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h1c00_0410, 32'h1c00_0410, 1'b1, 4'h8, 1'b1, 1'b0);
        idle(1'b1, 6);

        // icache stalled: only faulted fetches get in
        step(1'b0, 1'b1, 32'h1c00_0500, 32'h1c00_0500, 1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h1c00_0504, 32'h1c00_0504, 1'b1, 4'h1, 1'b0, 1'b1);
        idle(1'b1, 3);

        // Async reset while a fetch is outstanding and a faulted entry is visible
        ic_delay = 5;
        step(1'b0, 1'b1, 32'h1c00_0600, 32'h1c00_0600, 1'b1, 4'h2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h1c00_0604, 32'h1c00_0604, 1'b0, 4'h0, 1'b1, 1'b0);
        check_eq("t6_pre_valid", 32'(out_valid), 32'd1);
        apply_reset();
        ic_delay = 3;
        step(1'b0, 1'b1, 32'h1c00_0700, 32'h1c00_0700, 1'b0, 4'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h1c00_0704, 32'h1c00_0704, 1'b0, 4'h0, 1'b1, 1'b1);
        idle(1'b1, 8);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] pa;
            pa = 32'($urandom);
            ic_delay = $urandom_range(1, 5);
            step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70), pa, pa ^ 32'h8000_0000,
                 ($urandom_range(0, 99) < 20), 4'($urandom), ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 60));
        end
        idle(1'b1, 12);
        check_eq("final_empty", 32'(mq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
